// File: rtl/modinv_helper_precalc_gen.sv
// Word-serial precalculation for the binary modular invertor: forward pass 2r,2s,r+s,u-v,v-u,
// backward pass u/2,v/2,(u-v)/2,(v-u)/2. Status flags u_eq_v/rps_carry live under MODINV_PRECALC_STATUS_EN.
module modinv_helper_precalc_gen #(
    parameter int NUM_WORDS = 9,
    parameter int ADDR_BITS = 4,
    parameter int WORD_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    output logic                 rdy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [WORD_W-1:0]    r_din,
    input  logic [WORD_W-1:0]    s_din,
    input  logic [WORD_W-1:0]    u_din,
    input  logic [WORD_W-1:0]    v_din,
    input  logic [WORD_W-1:0]    umv_din,
    input  logic [WORD_W-1:0]    vmu_din,
    output logic [ADDR_BITS-1:0] fwd_wr_addr,
    output logic                 fwd_wren,
    output logic [ADDR_BITS-1:0] bwd_wr_addr,
    output logic                 bwd_wren,
    output logic [WORD_W-1:0]    r_dbl_dout,
    output logic [WORD_W-1:0]    s_dbl_dout,
    output logic [WORD_W-1:0]    r_plus_s_dout,
    output logic [WORD_W-1:0]    u_minus_v_dout,
    output logic [WORD_W-1:0]    v_minus_u_dout,
    output logic [WORD_W-1:0]    u_half_dout,
    output logic [WORD_W-1:0]    v_half_dout,
    output logic [WORD_W-1:0]    umv_half_dout,
    output logic [WORD_W-1:0]    vmu_half_dout,
    output logic                 u_lt_v,
    output logic                 v_lt_u,
    output logic                 u_eq_v,
    output logic                 rps_carry
);

    localparam int CNT_W = $clog2(2*NUM_WORDS + 5);

    // t milestones; data for a read issued at cycle t is consumed at cycle t+1
    localparam logic [CNT_W-1:0] T_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_FLAST      = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] T_FLAST_DATA = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] T_FDRN_END   = CNT_W'(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] T_BRD0       = CNT_W'(NUM_WORDS + 2);
    localparam logic [CNT_W-1:0] T_BFIRST     = CNT_W'(NUM_WORDS + 3);
    localparam logic [CNT_W-1:0] T_BLAST      = CNT_W'(2*NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] T_BLAST_DATA = CNT_W'(2*NUM_WORDS + 2);
    localparam logic [CNT_W-1:0] T_END        = CNT_W'(2*NUM_WORDS + 3);

    typedef enum logic [2:0] {IDLE, FWD, FWD_DRAIN, BWD, BWD_DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   t;
    logic [CNT_W-1:0]   t_nxt;
    logic [ADDR_BITS-1:0] rd_nxt;
    logic               fwd_vld, fwd_first, bwd_vld, bwd_first;
    logic               rps_c, umv_b, vmu_b, r_msb, s_msb;
    logic               u_lsb, v_lsb, umv_lsb, vmu_lsb;
    logic [WORD_W:0]    sum, umv, vmu;

    always_comb begin
        t_nxt     = t + 1'b1;
        fwd_vld   = (state != IDLE) && (t >= T_ONE) && (t <= T_FLAST_DATA);
        fwd_first = (t == T_ONE);
        bwd_vld   = (state != IDLE) && (t >= T_BFIRST) && (t <= T_BLAST_DATA);
        bwd_first = (t == T_BFIRST);
        sum = {1'b0, r_din} + {1'b0, s_din} + (WORD_W+1)'(fwd_first ? 1'b0 : rps_c);
        umv = {1'b0, u_din} - {1'b0, v_din} - (WORD_W+1)'(fwd_first ? 1'b0 : umv_b);
        vmu = {1'b0, v_din} - {1'b0, u_din} - (WORD_W+1)'(fwd_first ? 1'b0 : vmu_b);
        if (t_nxt <= T_FLAST)
            rd_nxt = ADDR_BITS'(t_nxt);
        else if (t_nxt >= T_BRD0 && t_nxt <= T_BLAST)
            rd_nxt = ADDR_BITS'(T_BLAST - t_nxt);
        else
            rd_nxt = '0;
    end

`ifndef MODINV_PRECALC_STATUS_EN
    assign u_eq_v    = 1'b0;
    assign rps_carry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t <= '0;
            rdy <= 1'b1;
            done <= 1'b0;
            rd_addr <= '0;
            fwd_wr_addr <= '0;
            fwd_wren <= 1'b0;
            bwd_wr_addr <= '0;
            bwd_wren <= 1'b0;
            r_dbl_dout <= '0;
            s_dbl_dout <= '0;
            r_plus_s_dout <= '0;
            u_minus_v_dout <= '0;
            v_minus_u_dout <= '0;
            u_half_dout <= '0;
            v_half_dout <= '0;
            umv_half_dout <= '0;
            vmu_half_dout <= '0;
            u_lt_v <= 1'b0;
            v_lt_u <= 1'b0;
`ifdef MODINV_PRECALC_STATUS_EN
            u_eq_v <= 1'b0;
            rps_carry <= 1'b0;
`endif
            {rps_c, umv_b, vmu_b, r_msb, s_msb} <= '0;
            {u_lsb, v_lsb, umv_lsb, vmu_lsb} <= '0;
        end else begin
            done <= 1'b0;
            fwd_wren <= fwd_vld;
            bwd_wren <= bwd_vld;
            if (state == IDLE) begin
                if (ena) begin
                    state <= FWD;
                    t <= '0;
                    rdy <= 1'b0;
                    rd_addr <= '0;
                end
            end else begin
                t <= t_nxt;
                rd_addr <= rd_nxt;
                case (state)
                    FWD:       if (t == T_FLAST) state <= FWD_DRAIN;
                    FWD_DRAIN: if (t == T_FDRN_END) state <= BWD;
                    BWD:       if (t == T_BLAST) state <= BWD_DRAIN;
                    BWD_DRAIN: if (t == T_END) begin
                        state <= IDLE;
                        t <= '0;
                        rdy <= 1'b1;
                        done <= 1'b1;
                    end
                    default:   state <= IDLE;
                endcase
            end

            if (fwd_vld) begin
                fwd_wr_addr <= ADDR_BITS'(t - 1'b1);
                r_dbl_dout <= {r_din[WORD_W-2:0], fwd_first ? 1'b0 : r_msb};
                s_dbl_dout <= {s_din[WORD_W-2:0], fwd_first ? 1'b0 : s_msb};
                r_plus_s_dout <= sum[WORD_W-1:0];
                u_minus_v_dout <= umv[WORD_W-1:0];
                v_minus_u_dout <= vmu[WORD_W-1:0];
                rps_c <= sum[WORD_W];
                umv_b <= umv[WORD_W];
                vmu_b <= vmu[WORD_W];
                r_msb <= r_din[WORD_W-1];
                s_msb <= s_din[WORD_W-1];
                if (t == T_FLAST_DATA) begin
                    u_lt_v <= umv[WORD_W];
                    v_lt_u <= vmu[WORD_W];
`ifdef MODINV_PRECALC_STATUS_EN
                    u_eq_v <= ~umv[WORD_W] & ~vmu[WORD_W];
                    rps_carry <= sum[WORD_W];
`endif
                end
            end else begin
                fwd_wr_addr <= '0;
            end

            // backward pass runs MSW first, so each fill bit comes from the word just seen
            if (bwd_vld) begin
                bwd_wr_addr <= ADDR_BITS'(T_BLAST_DATA - t);
                u_half_dout <= {bwd_first ? 1'b0 : u_lsb, u_din[WORD_W-1:1]};
                v_half_dout <= {bwd_first ? 1'b0 : v_lsb, v_din[WORD_W-1:1]};
                umv_half_dout <= {bwd_first ? 1'b0 : umv_lsb, umv_din[WORD_W-1:1]};
                vmu_half_dout <= {bwd_first ? 1'b0 : vmu_lsb, vmu_din[WORD_W-1:1]};
                u_lsb <= u_din[0];
                v_lsb <= v_din[0];
                umv_lsb <= umv_din[0];
                vmu_lsb <= vmu_din[0];
            end else begin
                bwd_wr_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_modinv_helper_precalc_gen.sv
// Bench for modinv_helper_precalc_gen: 1-cycle buffer models, wide-integer reference model.
module tb_modinv_helper_precalc_gen;

    localparam int N   = 9;
    localparam int AB  = 4;
    localparam int W   = 32;
    localparam int TOT = N * W;
    localparam logic [W-1:0] SENT = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic rdy, done, fwd_wren, bwd_wren;
    logic [AB-1:0] rd_addr, fwd_wr_addr, bwd_wr_addr;
    logic [W-1:0] r_din, s_din, u_din, v_din, umv_din, vmu_din;
    logic [W-1:0] r_dbl_dout, s_dbl_dout, r_plus_s_dout, u_minus_v_dout, v_minus_u_dout;
    logic [W-1:0] u_half_dout, v_half_dout, umv_half_dout, vmu_half_dout;
    logic u_lt_v, v_lt_u, u_eq_v, rps_carry;

    logic [W-1:0] r_mem[16], s_mem[16], u_mem[16], v_mem[16];
    logic [W-1:0] rdbl_c[16], sdbl_c[16], rps_c[16], umv_c[16], vmu_c[16];
    logic [W-1:0] uh_c[16], vh_c[16], umvh_c[16], vmuh_c[16];

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    modinv_helper_precalc_gen #(.NUM_WORDS(N), .ADDR_BITS(AB), .WORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy), .done(done), .rd_addr(rd_addr),
        .r_din(r_din), .s_din(s_din), .u_din(u_din), .v_din(v_din),
        .umv_din(umv_din), .vmu_din(vmu_din),
        .fwd_wr_addr(fwd_wr_addr), .fwd_wren(fwd_wren),
        .bwd_wr_addr(bwd_wr_addr), .bwd_wren(bwd_wren),
        .r_dbl_dout(r_dbl_dout), .s_dbl_dout(s_dbl_dout), .r_plus_s_dout(r_plus_s_dout),
        .u_minus_v_dout(u_minus_v_dout), .v_minus_u_dout(v_minus_u_dout),
        .u_half_dout(u_half_dout), .v_half_dout(v_half_dout),
        .umv_half_dout(umv_half_dout), .vmu_half_dout(vmu_half_dout),
        .u_lt_v(u_lt_v), .v_lt_u(v_lt_u), .u_eq_v(u_eq_v), .rps_carry(rps_carry)
    );

    // buffers: synchronous read, write-enabled capture; u-v/v-u captures feed the readback ports
    always @(posedge clk) begin
        r_din <= r_mem[rd_addr];
        s_din <= s_mem[rd_addr];
        u_din <= u_mem[rd_addr];
        v_din <= v_mem[rd_addr];
        umv_din <= umv_c[rd_addr];
        vmu_din <= vmu_c[rd_addr];
        if (fwd_wren) begin
            rdbl_c[fwd_wr_addr] <= r_dbl_dout;
            sdbl_c[fwd_wr_addr] <= s_dbl_dout;
            rps_c[fwd_wr_addr]  <= r_plus_s_dout;
            umv_c[fwd_wr_addr]  <= u_minus_v_dout;
            vmu_c[fwd_wr_addr]  <= v_minus_u_dout;
        end
        if (bwd_wren) begin
            uh_c[bwd_wr_addr]   <= u_half_dout;
            vh_c[bwd_wr_addr]   <= v_half_dout;
            umvh_c[bwd_wr_addr] <= umv_half_dout;
            vmuh_c[bwd_wr_addr] <= vmu_half_dout;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 16; i++) begin
            r_mem[i] = '0; s_mem[i] = '0; u_mem[i] = '0; v_mem[i] = '0;
        end
    endtask

    task automatic clear_captures();
        for (int i = 0; i < 16; i++) begin
            rdbl_c[i] = SENT; sdbl_c[i] = SENT; rps_c[i] = SENT; umv_c[i] = SENT; vmu_c[i] = SENT;
            uh_c[i] = SENT; vh_c[i] = SENT; umvh_c[i] = SENT; vmuh_c[i] = SENT;
        end
    endtask

    task automatic check_results(input string name);
        logic [TOT-1:0] rr, ss, uu, vv, umv, vmu;
        logic [TOT:0]   rps;
        logic [TOT-1:0] e_rdbl, e_sdbl, e_uh, e_vh, e_umvh, e_vmuh;
        logic e_eq, e_carry;
        for (int i = 0; i < N; i++) begin
            rr[i*W +: W] = r_mem[i];
            ss[i*W +: W] = s_mem[i];
            uu[i*W +: W] = u_mem[i];
            vv[i*W +: W] = v_mem[i];
        end
        e_rdbl = rr << 1;
        e_sdbl = ss << 1;
        rps = {1'b0, rr} + {1'b0, ss};
        umv = uu - vv;
        vmu = vv - uu;
        e_uh = uu >> 1;
        e_vh = vv >> 1;
        e_umvh = umv >> 1;
        e_vmuh = vmu >> 1;
`ifdef MODINV_PRECALC_STATUS_EN
        e_eq = (uu == vv);
        e_carry = rps[TOT];
`else
        e_eq = 1'b0;
        e_carry = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s r_dbl[%0d]", name, i), rdbl_c[i], e_rdbl[i*W +: W]);
            check($sformatf("%s s_dbl[%0d]", name, i), sdbl_c[i], e_sdbl[i*W +: W]);
            check($sformatf("%s r_plus_s[%0d]", name, i), rps_c[i], rps[i*W +: W]);
            check($sformatf("%s u_minus_v[%0d]", name, i), umv_c[i], umv[i*W +: W]);
            check($sformatf("%s v_minus_u[%0d]", name, i), vmu_c[i], vmu[i*W +: W]);
            check($sformatf("%s u_half[%0d]", name, i), uh_c[i], e_uh[i*W +: W]);
            check($sformatf("%s v_half[%0d]", name, i), vh_c[i], e_vh[i*W +: W]);
            check($sformatf("%s umv_half[%0d]", name, i), umvh_c[i], e_umvh[i*W +: W]);
            check($sformatf("%s vmu_half[%0d]", name, i), vmuh_c[i], e_vmuh[i*W +: W]);
        end
        check($sformatf("%s flags lt/lt/eq/carry", name),
              {u_lt_v, v_lt_u, u_eq_v, rps_carry}, {uu < vv, vv < uu, e_eq, e_carry});
    endtask

    // Runs one operation from the negedge before ena; checks control timing every cycle.
    task automatic run_op(input string name, input bit ena_mid);
        logic [3:0] exp_ctl;
        clear_captures();
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        for (int t = 0; t <= 2*N + 4; t++) begin
            exp_ctl = {t == 2*N+4, t == 2*N+4, (t >= 2 && t <= N+1), (t >= N+4 && t <= 2*N+3)};
            check($sformatf("%s ctl rdy/done/fwd/bwd t=%0d", name, t),
                  {rdy, done, fwd_wren, bwd_wren}, exp_ctl);
            ena = ena_mid && (t == 7);
            if (t < 2*N + 4) @(negedge clk);
        end
        ena = 1'b0;
        @(negedge clk);
        check($sformatf("%s done pulse ends", name), {rdy, done}, 2'b10);
        check_results(name);
    endtask

    initial begin
        clear_inputs();
        clear_captures();
        repeat (2) @(negedge clk);
        check("reset ctl", {rdy, done, fwd_wren, bwd_wren}, 4'b1000);
        check("reset addrs", {rd_addr, fwd_wr_addr, bwd_wr_addr}, '0);
        check("reset flags", {u_lt_v, v_lt_u, u_eq_v, rps_carry}, '0);
        check("reset douts", {r_dbl_dout, r_plus_s_dout, u_half_dout, vmu_half_dout}, '0);
        rst_n = 1'b1;

        // u=5, v=3, with a mid-operation ena that must be ignored
        clear_inputs();
        u_mem[0] = 32'd5; v_mem[0] = 32'd3;
        run_op("t1", 1'b1);
        check("t1 vmu w0", vmu_c[0], 32'hFFFF_FFFE);
        check("t1 umvh w0", umvh_c[0], 32'd1);

        clear_inputs();
        r_mem[0] = 32'h8000_0000;
        run_op("t2", 1'b0);
        check("t2 r_dbl w1", rdbl_c[1], 32'd1);

        clear_inputs();
        u_mem[1] = 32'd1; v_mem[1] = 32'd1;
        run_op("t3", 1'b0);
        check("t3 u_half w0", uh_c[0], 32'h8000_0000);

        clear_inputs();
        for (int i = 0; i < N; i++) begin
            r_mem[i] = '1; s_mem[i] = '1;
        end
        run_op("t4", 1'b0);
        check("t4 rps w0", rps_c[0], 32'hFFFF_FFFE);

        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) begin
                r_mem[i] = $urandom; s_mem[i] = $urandom;
                u_mem[i] = $urandom; v_mem[i] = (k == 2) ? u_mem[i] : $urandom;
            end
            if (k == 3) u_mem[N-1] = v_mem[N-1];
            run_op($sformatf("rnd%0d", k), 1'b0);
        end

        // asynchronous reset in the middle of an operation, then a clean rerun
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ctl", {rdy, done, fwd_wren, bwd_wren}, 4'b1000);
        check("midrst addrs", {rd_addr, fwd_wr_addr, bwd_wr_addr}, '0);
        check("midrst flags", {u_lt_v, v_lt_u, u_eq_v, rps_carry}, '0);
        check("midrst douts", {r_dbl_dout, u_minus_v_dout}, '0);
        @(negedge clk) rst_n = 1'b1;
        run_op("postrst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
